// File: rtl/tm1638_pkg.sv
// Shared TM1638 definitions: command codes, key-scan geometry, state
// encoding and helpers common to the read and write paths.
package tm1638_pkg;

    localparam logic [7:0] CMD_READ_KEYS = 8'h42;
    localparam int         KEY_BYTES     = 4;
    localparam int         KEY_BITS      = KEY_BYTES * 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        CMD   = 3'd2,
        WAIT  = 3'd3,
        READ  = 3'd4,
        DONE  = 3'd5
    } key_state_t;

    // SPI half-period in system clocks; the write path expands its
    // SPI_CYCLES parameter the same way, so both sides share this.
    function automatic int spi_half_period(input int spi_cycles);
        return spi_cycles + 1;
    endfunction

    // Button k (k=0..3) is bit 0 of key byte k, button k+4 is bit 4 of
    // key byte k. Byte k occupies keys[8k+7:8k].
    function automatic logic [7:0] decode_buttons(input logic [KEY_BITS-1:0] keys);
        return {keys[28], keys[20], keys[12], keys[4],
                keys[24], keys[16], keys[8],  keys[0]};
    endfunction

endpackage

// File: rtl/tm1638_key_reader_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_D,
    output logic o_Q
);

    logic meta_r;
    logic sync_r;

    // Resample the asynchronous input twice to settle metastability.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= i_D;
            sync_r <= meta_r;
        end
    end

    assign o_Q = sync_r;

endmodule

// File: rtl/tm1638_key_reader.sv
// TM1638 key-scan reader: sends the read-keys command, releases DIO and
// shifts in the four key bytes the device returns, LSB first.
module tm1638_key_reader
    import tm1638_pkg::*;
#(
    parameter int SPI_CYCLES  = 4,
    parameter int WAIT_CYCLES = 32
) (
    input  logic                i_Clk,
    input  logic                i_Rst_n,
    input  logic                i_Start,
    output logic                o_Busy,
    output logic [KEY_BITS-1:0] o_Keys,
    output logic                o_Keys_Valid,
    output logic [7:0]          o_Buttons,
    output logic                o_SPI_Stb,
    output logic                o_SPI_Clk,
    output logic                o_SPI_Dio,
    output logic                o_SPI_Dio_Oe,
    input  logic                i_SPI_Dio
);

    localparam int H       = spi_half_period(SPI_CYCLES);
    localparam int CNT_MAX = (H > WAIT_CYCLES) ? H : WAIT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H - 1);
    localparam logic [CNT_W-1:0] W_LAST   = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [4:0]       CMD_LAST = 5'd7;
    localparam logic [4:0]       KEY_LAST = 5'(KEY_BITS - 1);

    key_state_t           state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [4:0]           bit_r;
    logic                 high_r;
    logic [KEY_BITS-2:0]  shift_r;
    logic [KEY_BITS-1:0]  keys_r;
    logic [7:0]           buttons_r;
    logic                 valid_r;
    logic                 busy_r;
    logic                 stb_r;
    logic                 clk_r;
    logic                 dio_r;
    logic                 oe_r;

    logic                 dio_sync_s;
    logic                 cnt_last_s;
    logic [4:0]           next_bit_s;
    logic                 cmd_next_dio_s;
    logic [KEY_BITS-1:0]  shift_next_s;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_dio_sync (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .i_D     (i_SPI_Dio),
        .o_Q     (dio_sync_s)
    );

    assign next_bit_s     = bit_r + 5'd1;
    assign cmd_next_dio_s = CMD_READ_KEYS[next_bit_s[2:0]];
    // Newest bit enters at the top; after 32 captures the first bit is bit 0.
    assign shift_next_s   = {dio_sync_s, shift_r};

    // Terminal count of the current phase: WAIT has its own length.
    always_comb begin
        cnt_last_s = 1'b0;
        if (state_r == WAIT) begin
            cnt_last_s = (cnt_r == W_LAST);
        end else begin
            cnt_last_s = (cnt_r == H_LAST);
        end
    end

    // Scan sequencer with all pin and result outputs registered.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            bit_r     <= 5'd0;
            high_r    <= 1'b0;
            shift_r   <= '0;
            keys_r    <= '0;
            buttons_r <= 8'h00;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            stb_r     <= 1'b1;
            clk_r     <= 1'b1;
            dio_r     <= 1'b1;
            oe_r      <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    cnt_r  <= '0;
                    bit_r  <= 5'd0;
                    high_r <= 1'b0;
                    if (i_Start) begin
                        state_r <= SETUP;
                        busy_r  <= 1'b1;
                        stb_r   <= 1'b0;
                        clk_r   <= 1'b1;
                        oe_r    <= 1'b1;
                        dio_r   <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                SETUP: begin
                    if (cnt_last_s) begin
                        state_r <= CMD;
                        cnt_r   <= '0;
                        bit_r   <= 5'd0;
                        high_r  <= 1'b0;
                        clk_r   <= 1'b0;
                        dio_r   <= CMD_READ_KEYS[0];
                    end else begin
                        cnt_r   <= cnt_r + 1'b1;
                    end
                end
                CMD: begin
                    if (!cnt_last_s) begin
                        cnt_r  <= cnt_r + 1'b1;
                    end else if (!high_r) begin
                        cnt_r  <= '0;
                        high_r <= 1'b1;
                        clk_r  <= 1'b1;
                    end else if (bit_r == CMD_LAST) begin
                        state_r <= WAIT;
                        cnt_r   <= '0;
                        high_r  <= 1'b0;
                        oe_r    <= 1'b0;
                        dio_r   <= 1'b1;
                    end else begin
                        cnt_r  <= '0;
                        bit_r  <= next_bit_s;
                        high_r <= 1'b0;
                        clk_r  <= 1'b0;
                        dio_r  <= cmd_next_dio_s;
                    end
                end
                WAIT: begin
                    if (cnt_last_s) begin
                        state_r <= READ;
                        cnt_r   <= '0;
                        bit_r   <= 5'd0;
                        high_r  <= 1'b0;
                        clk_r   <= 1'b0;
                    end else begin
                        cnt_r   <= cnt_r + 1'b1;
                    end
                end
                READ: begin
                    if (!cnt_last_s) begin
                        cnt_r  <= cnt_r + 1'b1;
                    end else if (!high_r) begin
                        cnt_r  <= '0;
                        high_r <= 1'b1;
                        clk_r  <= 1'b1;
                    end else begin
                        // Last clock of the high half: capture this bit.
                        cnt_r   <= '0;
                        shift_r <= shift_next_s[KEY_BITS-1:1];
                        if (bit_r == KEY_LAST) begin
                            state_r   <= DONE;
                            high_r    <= 1'b0;
                            stb_r     <= 1'b1;
                            keys_r    <= shift_next_s;
                            buttons_r <= decode_buttons(shift_next_s);
                            valid_r   <= 1'b1;
                        end else begin
                            bit_r  <= next_bit_s;
                            high_r <= 1'b0;
                            clk_r  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    // Holds strobe high for the device's minimum idle time.
                    if (cnt_last_s) begin
                        state_r <= IDLE;
                        cnt_r   <= '0;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r   <= cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    bit_r   <= 5'd0;
                    high_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    stb_r   <= 1'b1;
                    clk_r   <= 1'b1;
                    dio_r   <= 1'b1;
                    oe_r    <= 1'b0;
                end
            endcase
        end
    end

    assign o_Busy       = busy_r;
    assign o_Keys       = keys_r;
    assign o_Keys_Valid = valid_r;
    assign o_Buttons    = buttons_r;
    assign o_SPI_Stb    = stb_r;
    assign o_SPI_Clk    = clk_r;
    assign o_SPI_Dio    = dio_r;
    assign o_SPI_Dio_Oe = oe_r;

endmodule

// File: tb/tb_tm1638_key_reader.sv
// Self-checking bench for tm1638_key_reader: a behavioural TM1638 answers
// each scan, and expected key words queued at start are compared on Valid.
module tb_tm1638_key_reader;

    localparam int SPI_A       = 4;
    localparam int WAIT_A      = 32;
    localparam int H_A         = SPI_A + 1;
    localparam int LAT_OE      = 1 + 17 * H_A;
    localparam int LAT_VALID   = 1 + 81 * H_A + WAIT_A;
    localparam int LAT_BUSY    = 1 + 82 * H_A + WAIT_A;
    localparam int SPI_B       = 2;
    localparam int WAIT_B      = 25;
    localparam int H_B         = SPI_B + 1;
    localparam int LAT_VALID_B = 1 + 81 * H_B + WAIT_B;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;

    // Free-running cycle counter used for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    logic        busy_a, valid_a, stb_a, sclk_a, dout_a, oe_a;
    logic [31:0] keys_a;
    logic [7:0]  btn_a;
    logic        dio_in_a = 1'b1;
    logic        busy_b, valid_b, stb_b, sclk_b, dout_b, oe_b;
    logic [31:0] keys_b;
    logic [7:0]  btn_b;
    logic        dio_in_b = 1'b1;

    tm1638_key_reader #(.SPI_CYCLES(SPI_A), .WAIT_CYCLES(WAIT_A)) dut_a (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start_a), .o_Busy(busy_a),
        .o_Keys(keys_a), .o_Keys_Valid(valid_a), .o_Buttons(btn_a),
        .o_SPI_Stb(stb_a), .o_SPI_Clk(sclk_a), .o_SPI_Dio(dout_a),
        .o_SPI_Dio_Oe(oe_a), .i_SPI_Dio(dio_in_a));

    tm1638_key_reader #(.SPI_CYCLES(SPI_B), .WAIT_CYCLES(WAIT_B)) dut_b (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start_b), .o_Busy(busy_b),
        .o_Keys(keys_b), .o_Keys_Valid(valid_b), .o_Buttons(btn_b),
        .o_SPI_Stb(stb_b), .o_SPI_Clk(sclk_b), .o_SPI_Dio(dout_b),
        .o_SPI_Dio_Oe(oe_b), .i_SPI_Dio(dio_in_b));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_buttons(input logic [31:0] k);
        logic [7:0] b0, b1, b2, b3;
        b0 = k[7:0];
        b1 = k[15:8];
        b2 = k[23:16];
        b3 = k[31:24];
        return {b3[4], b2[4], b1[4], b0[4], b3[0], b2[0], b1[0], b0[0]};
    endfunction

    // ---------------- device models ----------------
    logic [31:0] resp_a = 32'h0;
    logic [7:0]  cmd_a = 8'h00;
    int          cmd_n_a = 0;
    int          rbit_a = 0;
    logic [31:0] resp_b = 32'h0;
    int          rbit_b = 0;

    always @(negedge stb_a) begin
        cmd_a = 8'h00; cmd_n_a = 0; rbit_a = 0;
    end
    always @(posedge sclk_a) if (!stb_a && oe_a) begin
        cmd_a = {dout_a, cmd_a[7:1]}; cmd_n_a++;
    end
    always @(negedge sclk_a) if (!stb_a && !oe_a && rbit_a < 32) begin
        dio_in_a = resp_a[rbit_a]; rbit_a++;
    end
    always @(negedge stb_b) rbit_b = 0;
    always @(negedge sclk_b) if (!stb_b && !oe_b && rbit_b < 32) begin
        dio_in_b = resp_b[rbit_b]; rbit_b++;
    end

    // ---------------- scoreboard for instance A ----------------
    logic [31:0] exp_q[$];
    int          valid_cyc_q[$];
    int          valid_cnt_a = 0;

    always @(negedge clk) if (rst_n && valid_a) begin
        logic [31:0] e;
        valid_cnt_a++;
        valid_cyc_q.push_back(cyc);
        check_eq("valid_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("keys", keys_a, e);
            check_eq("buttons", 32'(btn_a), 32'(exp_buttons(e)));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int t0, rel, base, k;
    int stb_low_at, oe_low_at, valid_at, busy_low_at, stb_high_at, nvalid, oe_rise;

    initial begin
        // Reset state, both instances.
        repeat (3) @(negedge clk);
        check_eq("rst_pins_a", {26'd0, stb_a, sclk_a, dout_a, oe_a, busy_a, valid_a}, 32'h38);
        check_eq("rst_keys_a", keys_a, 32'h0);
        check_eq("rst_btn_a", 32'(btn_a), 32'h0);
        check_eq("rst_pins_b", {26'd0, stb_b, sclk_b, dout_b, oe_b, busy_b, valid_b}, 32'h38);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check_eq("idle_pins_a", {26'd0, stb_a, sclk_a, dout_a, oe_a, busy_a, valid_a}, 32'h38);
        check_eq("idle_keys_a", keys_a, 32'h0);
        check_eq("idle_valid_cnt", valid_cnt_a, 0);

        // Basic scan with timing measurements.
        resp_a = 32'h4402_1001;
        exp_q.push_back(resp_a);
        t0 = cyc; start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        stb_low_at = -1; oe_low_at = -1; valid_at = -1; busy_low_at = -1;
        stb_high_at = -1; nvalid = 0; oe_rise = 0;
        for (int i = 0; i < LAT_BUSY + 10; i++) begin
            rel = cyc - t0;
            if (stb_low_at < 0 && !stb_a) stb_low_at = rel;
            if (stb_low_at >= 0 && oe_low_at >= 0 && oe_a) oe_rise++;
            if (stb_low_at >= 0 && oe_low_at < 0 && !oe_a) oe_low_at = rel;
            if (valid_a) begin nvalid++; if (valid_at < 0) valid_at = rel; end
            if (stb_low_at >= 0 && stb_high_at < 0 && stb_a) stb_high_at = rel;
            if (stb_low_at >= 0 && busy_low_at < 0 && !busy_a) busy_low_at = rel;
            @(negedge clk);
        end
        check_eq("stb_low_cycle", stb_low_at, 1);
        check_eq("oe_low_cycle", oe_low_at, LAT_OE);
        check_eq("oe_stays_low", oe_rise, 0);
        check_eq("valid_cycle", valid_at, LAT_VALID);
        check_eq("valid_count", nvalid, 1);
        check_eq("stb_high_cycle", stb_high_at, LAT_VALID);
        check_eq("busy_low_cycle", busy_low_at, LAT_BUSY);
        check_eq("cmd_byte", 32'(cmd_a), 32'h42);
        check_eq("cmd_bits", cmd_n_a, 8);
        check_eq("keys_hold", keys_a, 32'h4402_1001);

        // Start pulse in the middle of a scan is ignored.
        resp_a = 32'h0000_0110;
        exp_q.push_back(resp_a);
        base = valid_cnt_a;
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        repeat (200) @(negedge clk);
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        repeat (LAT_BUSY + 10) @(negedge clk);
        check_eq("midscan_start_valids", valid_cnt_a - base, 1);
        check_eq("midscan_busy_end", 32'(busy_a), 32'd0);

        // Start held high: back-to-back scans; the next start is sampled in
        // the first busy-low cycle, so Valid repeats every LAT_BUSY clocks.
        resp_a = 32'hF0F0_1111;
        repeat (3) exp_q.push_back(resp_a);
        valid_cyc_q.delete();
        t0 = cyc; start_a = 1'b1;
        k = 0;
        while (valid_cyc_q.size() < 3 && k < 3 * LAT_BUSY + 50) begin
            @(negedge clk); k++;
        end
        start_a = 1'b0;
        check_eq("b2b_valid_count", valid_cyc_q.size(), 3);
        if (valid_cyc_q.size() == 3) begin
            check_eq("b2b_first", valid_cyc_q[0] - t0, LAT_VALID);
            check_eq("b2b_period1", valid_cyc_q[1] - valid_cyc_q[0], LAT_BUSY);
            check_eq("b2b_period2", valid_cyc_q[2] - valid_cyc_q[1], LAT_BUSY);
        end
        k = 0;
        while (busy_a && k < LAT_BUSY) begin @(negedge clk); k++; end
        check_eq("b2b_idle", 32'(busy_a), 32'd0);
        repeat (3) @(negedge clk);

        // Reset asserted during READ at bit 17.
        resp_a = 32'hA5C3_0F69;
        base = valid_cnt_a;
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        k = 0;
        while (rbit_a != 17 && k < LAT_BUSY) begin @(negedge clk); k++; end
        check_eq("reached_bit17", rbit_a, 17);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_pins", {26'd0, stb_a, sclk_a, dout_a, oe_a, busy_a, valid_a}, 32'h38);
        check_eq("midrst_keys", keys_a, 32'h0);
        check_eq("midrst_btn", 32'(btn_a), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT_BUSY) @(negedge clk);
        check_eq("midrst_no_valid", valid_cnt_a - base, 0);
        resp_a = 32'h8E11_F0A5;
        exp_q.push_back(resp_a);
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        repeat (LAT_BUSY + 10) @(negedge clk);
        check_eq("post_rst_valids", valid_cnt_a - base, 1);
        check_eq("post_rst_cmd", 32'(cmd_a), 32'h42);
        check_eq("sb_drained", exp_q.size(), 0);

        // Minimum half-period instance, all keys pressed.
        resp_b = 32'hFFFF_FFFF;
        t0 = cyc; start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        valid_at = -1;
        k = 0;
        while (valid_at < 0 && k < LAT_VALID_B + 20) begin
            if (valid_b) valid_at = cyc - t0;
            else begin @(negedge clk); k++; end
        end
        check_eq("b_valid_cycle", valid_at, LAT_VALID_B);
        check_eq("b_keys", keys_b, 32'hFFFF_FFFF);
        check_eq("b_buttons", 32'(btn_b), 32'(exp_buttons(resp_b)));
        repeat (10) @(negedge clk);
        check_eq("b_idle", 32'(busy_b), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
